// File: rtl/instr_fetch_pkg.sv
// Shared constants and the state encoding for the fetch stage.
// Imported by the fetch top and its next-address mux.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_2000;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Priority mux that picks the address the instruction memory latches on the
// coming edge.
module instr_fetch_pc_next_sel
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  fetch_state_t state,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  input  logic         imem_valid,
  input  logic [31:0]  req_pc,
  output logic [31:0]  next_pc
);

  always_comb begin
    next_pc = req_pc + PC_INC;
    if (state == BOOT) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = redirect_pc & ~32'd3;
    end else if (stall || !imem_valid) begin
      // Re-present the same address so imem_dout repeats next cycle.
      next_pc = req_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the synchronous-read instruction memory and
// hands instruction, PC and bubble flag to decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        bubble
);

  fetch_state_t state_reg;
  fetch_state_t state_next;
  logic [31:0]  req_pc_reg;

  instr_fetch_pc_next_sel #(
    .RESET_PC(RESET_PC)
  ) u_pc_next_sel (
    .state      (state_reg),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_valid (imem_valid),
    .req_pc     (req_pc_reg),
    .next_pc    (imem_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= BOOT;
      req_pc_reg <= RESET_PC;
    end else begin
      state_reg  <= state_next;
      req_pc_reg <= imem_addr;
    end
  end

  always_comb begin
    state_next = RUN;
    pc         = req_pc_reg;
    // A redirect kills whatever is at decode this cycle, stalled or not.
    bubble     = (state_reg == BOOT) || !imem_valid || redirect;
    instr      = bubble ? NOP_INSTR : imem_dout;
  end

endmodule
